// File: rtl/imm_operand_encoder_if.sv
// Start/result handshake between a requester and the immediate operand encoder.
interface imm_operand_encoder_if;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic [11:0] shifter_operand;
    logic        inverted;

    modport master (
        output start, value,
        input  busy, done, valid, shifter_operand, inverted
    );

    modport slave (
        input  start, value,
        output busy, done, valid, shifter_operand, inverted
    );
endinterface

// File: rtl/imm_operand_encoder.sv
// Immediate operand encoder: searches for {rotate_imm, imm8} such that
// ROR(imm8, 2*rotate_imm) reproduces a 32-bit constant, one rotation per clock.
// Optional build macro IMM_INVERT_EN adds a second search over ~value
// (MOV/MVN swap) reported through the inverted output.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; result outputs hold the last result
// SEARCH | evaluating rotation rot_cnt of val_q (direct or inverted)
// DONE   | done pulse, result valid; returns to IDLE next cycle
module imm_operand_encoder #(
    parameter int ROT_STEPS = 16
) (
    input  logic clk,
    input  logic rst,
    imm_operand_encoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

    state_t      state;
    logic [31:0] val_q;
    logic [3:0]  rot_cnt;
    logic        busy_q;
    logic        done_q;
    logic        valid_q;
    logic [11:0] op_q;

    logic [4:0]  shamt;
    logic [31:0] cand;
    logic        hit;
    logic        last_rot;

`ifdef IMM_INVERT_EN
    logic        phase;
    logic        inv_q;
`endif

    // Left-rotate the latched value by 2*rot_cnt; a hit needs the top 24 bits clear.
    always_comb begin
        shamt    = {rot_cnt, 1'b0};
        cand     = (val_q << shamt) | (val_q >> (6'd32 - {1'b0, shamt}));
        hit      = (cand[31:8] == 24'd0);
        last_rot = (rot_cnt == ROT_LAST);
    end

    // Search sequencer with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            val_q   <= '0;
            rot_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            op_q    <= '0;
`ifdef IMM_INVERT_EN
            phase   <= 1'b0;
            inv_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        val_q   <= bus.value;
                        rot_cnt <= '0;
                        busy_q  <= 1'b1;
`ifdef IMM_INVERT_EN
                        phase   <= 1'b0;
`endif
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        op_q    <= {rot_cnt, cand[7:0]};
                        valid_q <= 1'b1;
                        done_q  <= 1'b1;
`ifdef IMM_INVERT_EN
                        inv_q   <= phase;
`endif
                        state   <= DONE;
                    end else if (!last_rot) begin
                        rot_cnt <= rot_cnt + 4'd1;
                    end else begin
`ifdef IMM_INVERT_EN
                        if (!phase) begin
                            // Direct value not encodable: retry with its complement.
                            phase   <= 1'b1;
                            val_q   <= ~val_q;
                            rot_cnt <= '0;
                        end else begin
                            op_q    <= '0;
                            valid_q <= 1'b0;
                            inv_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end
`else
                        op_q    <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
`endif
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.valid           = valid_q;
    assign bus.shifter_operand = op_q;
`ifdef IMM_INVERT_EN
    assign bus.inverted        = inv_q;
`else
    assign bus.inverted        = 1'b0;
`endif

endmodule
